// File: rtl/alu_iterative_pkg.sv
// Shared op codes, FSM state encoding and op classification for the KGP-RISC iterative ALU.
// The ALU control stage imports the same constants so both ends agree on the encoding.
package kgp_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_COMP = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_DIFF = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SCAN  = 2'd2
    } state_t;

    // Ops that may need more than one cycle (shifts by >0, DIFF with a!=b)
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_DIFF);
    endfunction

endpackage

// File: rtl/alu_single_cycle.sv
// Combinational ADD/COMP/AND/XOR datapath; carry is the bit above the result.
module alu_single_cycle
    import kgp_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
            OP_COMP: {carry, result} = {1'b0, ~b} + (WIDTH+1)'(1);
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_iterative.sv
// Multi-cycle ALU: single-cycle ops complete on the accepting edge, shifts move one bit
// per cycle, DIFF scans a^b one bit per cycle for the lowest differing position.
module alu_iterative
    import kgp_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control_signal,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             sign,
    output logic             illegal
);

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_op, w_op_nxt;
    logic [WIDTH-1:0] r_work, w_work_nxt;
    logic [SHW-1:0]   r_cnt, w_cnt_nxt;
    logic [SHW-1:0]   r_idx, w_idx_nxt;
    logic [WIDTH-1:0] r_result, w_res_nxt;
    logic             r_carry, w_carry_nxt;
    logic             r_zero, r_sign, r_done, r_illegal;
    logic             w_done_nxt, w_illegal_nxt;

    logic [WIDTH-1:0] w_sc_result;
    logic             w_sc_carry;
    logic [WIDTH-1:0] w_shifted;
    logic             w_shift_out;

    alu_single_cycle #(.WIDTH(WIDTH)) u_single (
        .op     (alu_control_signal),
        .a      (a),
        .b      (b),
        .result (w_sc_result),
        .carry  (w_sc_carry)
    );

    always_comb begin
        w_shifted   = r_work;
        w_shift_out = 1'b0;
        case (r_op)
            OP_SLL: begin
                w_shifted   = {r_work[WIDTH-2:0], 1'b0};
                w_shift_out = r_work[WIDTH-1];
            end
            OP_SRL: begin
                w_shifted   = {1'b0, r_work[WIDTH-1:1]};
                w_shift_out = r_work[0];
            end
            OP_SRA: begin
                w_shifted   = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
                w_shift_out = r_work[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_work_nxt    = r_work;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_res_nxt     = r_result;
        w_carry_nxt   = r_carry;
        w_done_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_op_nxt = alu_control_signal;
                    if (alu_control_signal[3]) begin
                        w_res_nxt     = '0;
                        w_carry_nxt   = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_illegal_nxt = 1'b1;
                    end else if (!is_iterative(alu_control_signal)) begin
                        w_res_nxt   = w_sc_result;
                        w_carry_nxt = w_sc_carry;
                        w_done_nxt  = 1'b1;
                    end else if (alu_control_signal == OP_DIFF) begin
                        if (a == b) begin
                            w_res_nxt   = WIDTH'(WIDTH);
                            w_carry_nxt = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_work_nxt  = a ^ b;
                            w_idx_nxt   = '0;
                            w_state_nxt = SCAN;
                        end
                    end else if (b[SHW-1:0] == '0) begin
                        // Nothing is shifted out, so carry reports 0
                        w_res_nxt   = a;
                        w_carry_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_work_nxt  = a;
                        w_cnt_nxt   = b[SHW-1:0];
                        w_state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_work_nxt = w_shifted;
                w_cnt_nxt  = r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    w_res_nxt   = w_shifted;
                    w_carry_nxt = w_shift_out;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            SCAN: begin
                if (r_work[0]) begin
                    w_res_nxt   = WIDTH'(r_idx);
                    w_carry_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_work_nxt = {1'b0, r_work[WIDTH-1:1]};
                    w_idx_nxt  = r_idx + SHW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // w_res_nxt equals r_result except on done edges, so flags track the new result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_work    <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_sign    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_work    <= w_work_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_result  <= w_res_nxt;
            r_carry   <= w_carry_nxt;
            r_zero    <= (w_res_nxt == '0);
            r_sign    <= w_res_nxt[WIDTH-1];
            r_done    <= w_done_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign result  = r_result;
    assign carry   = r_carry;
    assign zero    = r_zero;
    assign sign    = r_sign;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative: hand-computed vectors, latency and handshake checks.
module tb_alu_iterative;

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_COMP = 4'b0001;
    localparam logic [3:0] C_AND  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SRA  = 4'b0110;
    localparam logic [3:0] C_DIFF = 4'b0111;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy, done, carry, zero, sign, illegal;
    logic [31:0] result;

    int tests_run;
    int tests_failed;

    alu_iterative #(.WIDTH(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .alu_control_signal (op),
        .a                  (a),
        .b                  (b),
        .busy               (busy),
        .done               (done),
        .result             (result),
        .carry              (carry),
        .zero               (zero),
        .sign               (sign),
        .illegal            (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op, drop start after acceptance, wait for done; returns edge count and busy cycles
    task automatic run_op(input logic [3:0] iop, input logic [31:0] ia, input logic [31:0] ib,
                          output int lat, output int bc);
        @(negedge clk);
        op = iop; a = ia; b = ib; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        bc  = 0;
        while (!done && lat < 100) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL timeout op=%b: no done after %0d edges", iop, lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b0)    begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (done !== 1'b0)    begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        tests_run++; if (result !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h want 0", result); end
        tests_run++; if ({carry, zero, sign, illegal} !== 4'b0000)
            begin tests_failed++; $display("FAIL reset_flags: got %b want 0000", {carry, zero, sign, illegal}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat, bc;
        run_op(C_ADD, 32'hFFFF_FFFF, 32'h1, lat, bc);
        tests_run++; if (lat !== 1)        begin tests_failed++; $display("FAIL add_latency: got %0d want 1", lat); end
        tests_run++; if (bc !== 0)         begin tests_failed++; $display("FAIL add_busy: got %0d busy cycles want 0", bc); end
        tests_run++; if (result !== 32'h0) begin tests_failed++; $display("FAIL add_result: got %h want 0", result); end
        tests_run++; if ({carry, zero, sign, illegal} !== 4'b1100)
            begin tests_failed++; $display("FAIL add_flags: got %b want 1100", {carry, zero, sign, illegal}); end
        @(posedge clk);
        #1;
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL add_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_comp();
        int lat, bc;
        run_op(C_COMP, 32'h0, 32'h5, lat, bc);
        tests_run++; if (result !== 32'hFFFF_FFFB) begin tests_failed++; $display("FAIL comp5_result: got %h want fffffffb", result); end
        tests_run++; if ({carry, zero, sign} !== 3'b001)
            begin tests_failed++; $display("FAIL comp5_flags: got %b want 001", {carry, zero, sign}); end
        run_op(C_COMP, 32'h1234, 32'h0, lat, bc);
        tests_run++; if (result !== 32'h0) begin tests_failed++; $display("FAIL comp0_result: got %h want 0", result); end
        tests_run++; if ({carry, zero, sign} !== 3'b110)
            begin tests_failed++; $display("FAIL comp0_flags: got %b want 110", {carry, zero, sign}); end
    endtask

    task automatic test_logic();
        int lat, bc;
        run_op(C_AND, 32'hF0F0_1234, 32'h0FF0_FF00, lat, bc);
        tests_run++; if (result !== 32'h00F0_1200) begin tests_failed++; $display("FAIL and_result: got %h want 00f01200", result); end
        tests_run++; if (carry !== 1'b0) begin tests_failed++; $display("FAIL and_carry: got %b want 0", carry); end
        run_op(C_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, lat, bc);
        tests_run++; if (result !== 32'hF0F0_0F0F) begin tests_failed++; $display("FAIL xor_result: got %h want f0f00f0f", result); end
        tests_run++; if ({carry, zero, sign} !== 3'b001)
            begin tests_failed++; $display("FAIL xor_flags: got %b want 001", {carry, zero, sign}); end
    endtask

    task automatic test_illegal();
        int lat, bc;
        run_op(4'b1010, 32'h5, 32'h6, lat, bc);
        tests_run++; if (lat !== 1)        begin tests_failed++; $display("FAIL illegal_latency: got %0d want 1", lat); end
        tests_run++; if (result !== 32'h0) begin tests_failed++; $display("FAIL illegal_result: got %h want 0", result); end
        tests_run++; if ({illegal, carry} !== 2'b10)
            begin tests_failed++; $display("FAIL illegal_flag: got %b want 10", {illegal, carry}); end
        @(posedge clk);
        #1;
        tests_run++; if ({illegal, done} !== 2'b00)
            begin tests_failed++; $display("FAIL illegal_pulse: got %b want 00", {illegal, done}); end
    endtask

    task automatic test_shift();
        int lat, bc;
        run_op(C_SRA, 32'h8000_0010, 32'h4, lat, bc);
        tests_run++; if (lat !== 5) begin tests_failed++; $display("FAIL sra_latency: got %0d want 5", lat); end
        tests_run++; if (bc !== 4)  begin tests_failed++; $display("FAIL sra_busy: got %0d want 4", bc); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL sra_busy_at_done: got %b want 0", busy); end
        tests_run++; if (result !== 32'hF800_0001) begin tests_failed++; $display("FAIL sra_result: got %h want f8000001", result); end
        tests_run++; if ({carry, sign, illegal} !== 3'b010)
            begin tests_failed++; $display("FAIL sra_flags: got %b want 010", {carry, sign, illegal}); end
        run_op(C_SLL, 32'h1, 32'h20, lat, bc);
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL sll0_latency: got %0d want 1", lat); end
        tests_run++; if (result !== 32'h1) begin tests_failed++; $display("FAIL sll0_result: got %h want 1", result); end
        run_op(C_SRL, 32'h8000_0001, 32'h1, lat, bc);
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL srl1_latency: got %0d want 2", lat); end
        tests_run++; if ({result, carry} !== {32'h4000_0000, 1'b1})
            begin tests_failed++; $display("FAIL srl1_result: got %h/%b want 40000000/1", result, carry); end
        run_op(C_SLL, 32'hC000_0000, 32'h2, lat, bc);
        tests_run++; if ({result, carry, zero} !== {32'h0, 1'b1, 1'b1})
            begin tests_failed++; $display("FAIL sll2_result: got %h/%b/%b want 0/1/1", result, carry, zero); end
        run_op(C_SLL, 32'h3, 32'h1F, lat, bc);
        tests_run++; if (lat !== 32) begin tests_failed++; $display("FAIL sll31_latency: got %0d want 32", lat); end
        tests_run++; if ({result, carry, sign} !== {32'h8000_0000, 1'b1, 1'b1})
            begin tests_failed++; $display("FAIL sll31_result: got %h/%b/%b want 80000000/1/1", result, carry, sign); end
    endtask

    task automatic test_diff();
        int lat, bc;
        run_op(C_DIFF, 32'h0000_0100, 32'h0, lat, bc);
        tests_run++; if (lat !== 10) begin tests_failed++; $display("FAIL diff8_latency: got %0d want 10", lat); end
        tests_run++; if ({result, carry} !== {32'd8, 1'b0})
            begin tests_failed++; $display("FAIL diff8_result: got %h/%b want 8/0", result, carry); end
        run_op(C_DIFF, 32'h1234, 32'h1234, lat, bc);
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL diffeq_latency: got %0d want 1", lat); end
        tests_run++; if (result !== 32'd32) begin tests_failed++; $display("FAIL diffeq_result: got %h want 20", result); end
        run_op(C_DIFF, 32'h8000_0000, 32'h0, lat, bc);
        tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL diff31_latency: got %0d want 33", lat); end
        tests_run++; if (result !== 32'd31) begin tests_failed++; $display("FAIL diff31_result: got %h want 1f", result); end
        run_op(C_DIFF, 32'h1, 32'h0, lat, bc);
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL diff0_latency: got %0d want 2", lat); end
        tests_run++; if ({result, zero} !== {32'h0, 1'b1})
            begin tests_failed++; $display("FAIL diff0_result: got %h/%b want 0/1", result, zero); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        op = C_SRL; a = 32'h0000_FFFF; b = 32'd10; start = 1'b1;
        @(posedge clk);
        #1;
        op = C_ADD; a = 32'd7; b = 32'd8;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy: got %b want 1", busy); end
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tests_run++; if (lat !== 11) begin tests_failed++; $display("FAIL b2b_srl_latency: got %0d want 11", lat); end
        tests_run++; if ({result, carry} !== {32'h0000_003F, 1'b1})
            begin tests_failed++; $display("FAIL b2b_srl_result: got %h/%b want 0000003f/1", result, carry); end
        @(posedge clk);
        #1;
        start = 1'b0;
        tests_run++; if ({done, result} !== {1'b1, 32'd15})
            begin tests_failed++; $display("FAIL b2b_add_no_gap: got %b/%h want 1/0000000f", done, result); end
        @(posedge clk);
        #1;
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL b2b_single_done: got %b want 0", done); end
    endtask

    task automatic test_reset_mid();
        int lat, bc, pulses;
        @(negedge clk);
        op = C_SLL; a = 32'h1; b = 32'd20; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if ({busy, done, carry, zero, sign, illegal} !== 6'b0)
            begin tests_failed++; $display("FAIL rstmid_flags: got %b want 000000", {busy, done, carry, zero, sign, illegal}); end
        tests_run++; if (result !== 32'h0) begin tests_failed++; $display("FAIL rstmid_result: got %h want 0", result); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL rstmid_no_done: got %0d pulses want 0", pulses); end
        run_op(C_ADD, 32'd2, 32'd3, lat, bc);
        tests_run++; if ({result, lat} !== {32'd5, 32'd1})
            begin tests_failed++; $display("FAIL rstmid_add: got %h in %0d edges want 5 in 1", result, lat); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_add();
        test_comp();
        test_logic();
        test_illegal();
        test_shift();
        test_diff();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Multi-cycle integer ALU for the KGP-RISC datapath, directly downstream of the ALU control stage: it consumes the 4-bit ALU control signal plus two operands and produces a registered result and flags. Add, complement, AND and XOR finish in one cycle. Shifts run one bit per cycle and DIFF scans one bit per cycle, both under a start/busy/done handshake. The block sits in the execute stage and stalls the multi-cycle controller via `busy`.

## Interface
- `WIDTH`, 32: operand/result width; must be a power of two ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only while `busy`=0.
- `alu_control_signal` in 4: operation code.
- `a` in WIDTH: operand A (shift source / DIFF lhs).
- `b` in WIDTH: operand B (COMP source, shift amount in `b[SHW-1:0]`, DIFF rhs).
- `busy` out 1: operation in progress; `start` ignored.
- `done` out 1: one-cycle pulse; result/flags valid.
- `result` out WIDTH: registered result; holds until next `done`.
- `carry` out 1: carry/last bit shifted out.
- `zero` out 1: `result`==0.
- `sign` out 1: `result[WIDTH-1]`.
- `illegal` out 1: pulses with `done` for an undefined code.

## Operation
- Codes: 0000 ADD (a+b), 0001 COMP (~b+1), 0010 AND, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SRA, 0111 DIFF. 1000–1111 are illegal.
- FSM: IDLE, SHIFT, SCAN.
  - IDLE + `start`: latch operands and op. Single-cycle op, illegal op, shift amount 0, or DIFF with a==b → stay IDLE, write result, pulse `done`.
  - Otherwise go to SHIFT (counter = amount) or SCAN (x = a^b, idx = 0).
- SHIFT: each edge shifts the working register 1 bit and decrements the counter.
  - SLL/SRL fill with 0; SRA fills with the sign bit.
  - `carry` = last bit shifted out.
  - On the edge where the counter reaches 0: write result, pulse `done`, go to IDLE.
- SCAN: each edge tests x[0].
  - x[0]=1 → result = idx, pulse `done`, go to IDLE.
  - x[0]=0 → x >>= 1, idx++.
- DIFF with a==b: result = WIDTH.
- ADD: `carry` = bit WIDTH of the (WIDTH+1)-bit sum. COMP: `carry` = carry out of ~b+1, so 1 only when b==0. Logic ops and DIFF: `carry`=0.
- Illegal op: result=0, carry=0, `illegal`=1 with `done`.
- `zero` and `sign` are computed from the new result and registered with it.
- Shift amount uses `b[SHW-1:0]` only; upper bits are ignored.

## Timing
- Reset (async assert, sync release): state IDLE; `busy`, `done`, `result`, `carry`, `zero`, `sign`, `illegal` all 0.
- Latency is counted from the edge that samples `start` to the cycle `done` is high:
  - single-cycle/illegal/shift-by-0/equal-DIFF: 1 edge;
  - shift by n: 1+n edges;
  - DIFF with lowest differing bit k: 2+k edges.
- `busy`=1 from the edge after acceptance through the edge that raises `done`. It is 0 in the `done` cycle, so back-to-back `start` in the `done` cycle is accepted.
- `start` while `busy`=1 is dropped, not queued. Operand changes during busy have no effect.
- Reset mid-operation aborts immediately; no `done` is produced.
- `result`/flags change only on `done` edges.

## Structure
- Package `kgp_alu_pkg`:
  - localparams for the eight op codes;
  - the state enum {IDLE, SHIFT, SCAN};
  - helper `is_iterative(op)`.
- The ALU control stage imports the same op-code constants.
- Sub-module `alu_single_cycle` (combinational): ADD/COMP/AND/XOR result and carry. It is instantiated once; the FSM, counter and working registers live in `alu_iterative`.

## Test plan
- ADD a=0xFFFFFFFF, b=1, start → `done` after 1 edge; result 0, carry 1, zero 1, sign 0, busy never high.
- COMP b=5 → result 0xFFFFFFFB, sign 1, carry 0. COMP b=0 → result 0, carry 1, zero 1.
- SRA a=0x80000010, b=4 → busy for 4 cycles, `done` at edge 5; result 0xF8000001, carry 0. SLL a=1, b=0x20 (amount 0) → result 1 in 1 edge.
- DIFF a=0x0000_0100, b=0 → `done` at edge 10, result 8. DIFF a=b=0x1234 → result 32 in 1 edge.
- Illegal code 1010 → result 0, `illegal`+`done` pulse. Then `start` during an SRL by 10 is ignored, and a new `start` held in the `done` cycle is accepted with no idle gap.
- Assert `rst_n`=0 mid-SHIFT → all outputs 0 immediately, no `done`; after release an ADD 2+3 gives 5.
